// File: rtl/pipeline_data_memory_pkg.sv
// Shared definitions for the pipeline data memory: default geometry and FSM encoding.
package pipeline_data_memory_pkg;

  localparam int unsigned DEF_BLOCK_W = 128;  // one cache line
  localparam int unsigned DEF_ADDR_W  = 28;   // 32-bit byte address >> 4
  localparam int unsigned DEF_DEPTH   = 64;   // blocks stored, power of two
  localparam int unsigned DEF_LATENCY = 5;    // edges from acceptance to completion

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : pipeline_data_memory_pkg

// File: rtl/pipeline_data_memory_array.sv
// Block storage array for the data memory.
// Ports:
//   clk_i      clock
//   rst_i      asynchronous active-high reset, clears every block
//   we_i       write enable for block idx_i
//   idx_i      block index (shared by read and write)
//   wdata_i    block to store
//   rdata_c_o  combinational read of block idx_i
module pipeline_data_memory_array #(
  parameter int unsigned BLOCK_W = 128,
  parameter int unsigned DEPTH   = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  input  logic [BLOCK_W-1:0]       wdata_i,
  output logic [BLOCK_W-1:0]       rdata_c_o
);

  logic [BLOCK_W-1:0] mem_q [DEPTH];

  // Storage: whole array clears on reset, single write port
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_c_o = mem_q[idx_i];

endmodule : pipeline_data_memory_array

// File: rtl/pipeline_data_memory.sv
// Main data memory behind the data cache: one 128-bit block read or write per
// request, completed LATENCY edges after acceptance, requester stalled by BUSYWAIT.
// Ports:
//   CLK        clock, rising edge
//   RESET      asynchronous active-high reset (clears array, READDATA, FSM)
//   READ       block read request, held until BUSYWAIT seen low
//   WRITE      block write request, held until BUSYWAIT seen low
//   ADDRESS    block address; low log2(DEPTH) bits select the block
//   WRITEDATA  block to store on write
//   READDATA   block returned by the last completed read (registered)
//   BUSYWAIT   stall, combinational: high in IDLE with a request, and in BUSY
module pipeline_data_memory
  import pipeline_data_memory_pkg::*;
#(
  parameter int unsigned BLOCK_W = DEF_BLOCK_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned LATENCY = DEF_LATENCY
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               READ,
  input  logic               WRITE,
  input  logic [ADDR_W-1:0]  ADDRESS,
  input  logic [BLOCK_W-1:0] WRITEDATA,
  output logic [BLOCK_W-1:0] READDATA,
  output logic               BUSYWAIT
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_wr_q, op_wr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BLOCK_W-1:0] wdata_q, wdata_d;
  logic [BLOCK_W-1:0] rdata_q, rdata_d;

  logic               req_c;
  logic               accept_c;
  logic               last_c;
  logic               busywait_c;
  logic               mem_we_c;
  logic               rd_done_c;
  logic [BLOCK_W-1:0] mem_rdata_c;

  // Upper block-address bits alias onto the same block
  logic unused_addr_hi;
  assign unused_addr_hi = ^ADDRESS[ADDR_W-1:IDX_W];

  assign req_c    = READ | WRITE;
  assign accept_c = (state_q == ST_IDLE) && req_c;
  assign last_c   = (state_q == ST_BUSY) && (cnt_q == CNT_W'(LATENCY));

  // FSM state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; DONE always returns to IDLE so a held request re-arbitrates there
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_c)  state_d = ST_BUSY;
      ST_BUSY: if (last_c) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; write wins when READ and WRITE are both latched
  always_comb begin
    busywait_c = 1'b0;
    mem_we_c   = 1'b0;
    rd_done_c  = 1'b0;
    case (state_q)
      ST_IDLE: busywait_c = req_c;
      ST_BUSY: begin
        busywait_c = 1'b1;
        mem_we_c   = last_c & op_wr_q;
        rd_done_c  = last_c & ~op_wr_q;
      end
      default: busywait_c = 1'b0;
    endcase
  end

  // Request latch, latency counter and read-data holding register
  always_comb begin
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (accept_c) begin
      op_wr_d = WRITE;
      idx_d   = ADDRESS[IDX_W-1:0];
      wdata_d = WRITEDATA;
      cnt_d   = CNT_W'(1);
    end else if (last_c) begin
      cnt_d = '0;
    end else if (state_q == ST_BUSY) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (rd_done_c) begin
      rdata_d = mem_rdata_c;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  pipeline_data_memory_array #(
    .BLOCK_W (BLOCK_W),
    .DEPTH   (DEPTH)
  ) u_array (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .we_i      (mem_we_c),
    .idx_i     (idx_q),
    .wdata_i   (wdata_q),
    .rdata_c_o (mem_rdata_c)
  );

  assign READDATA = rdata_q;
  assign BUSYWAIT = busywait_c;

endmodule : pipeline_data_memory

// File: tb/tb_pipeline_data_memory.sv
// Self-checking bench for pipeline_data_memory against a block-level reference model.
module tb_pipeline_data_memory;
  import pipeline_data_memory_pkg::*;

  localparam int LAT   = int'(DEF_LATENCY);
  localparam int NBLK  = int'(DEF_DEPTH);

  logic         CLK = 1'b0;
  logic         RESET;
  logic         READ;
  logic         WRITE;
  logic [27:0]  ADDRESS;
  logic [127:0] WRITEDATA;
  logic [127:0] READDATA;
  logic         BUSYWAIT;

  always #2 CLK = ~CLK;

  pipeline_data_memory dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .READ      (READ),
    .WRITE     (WRITE),
    .ADDRESS   (ADDRESS),
    .WRITEDATA (WRITEDATA),
    .READDATA  (READDATA),
    .BUSYWAIT  (BUSYWAIT)
  );

  // Reference model: block array plus last-read register
  logic [127:0] ref_mem [NBLK];
  logic [127:0] ref_rdata;
  int vectors = 0;
  int miscompares = 0;

  function automatic void ref_reset();
    for (int i = 0; i < NBLK; i++) ref_mem[i] = '0;
    ref_rdata = '0;
  endfunction

  function automatic void ref_access(input bit rd, input bit wr, input logic [27:0] addr,
                                     input logic [127:0] data);
    int unsigned idx;
    idx = int'(addr) % NBLK;
    if (wr) ref_mem[idx] = data;
    else if (rd) ref_rdata = ref_mem[idx];
  endfunction

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One full handshake; request inputs are scrambled after acceptance to prove latching
  task automatic do_req(input bit rd, input bit wr, input logic [27:0] addr,
                        input logic [127:0] data, output int busy);
    @(posedge CLK); #1;
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = data;
    busy = 0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (!BUSYWAIT) break;
      busy++;
      @(posedge CLK); #1;
      ADDRESS = 28'($urandom);
      WRITEDATA = rand_block();
    end
    READ = 1'b0; WRITE = 1'b0;
    ref_access(rd, wr, addr, data);
  endtask

  task automatic test_reset();
    int busy;
    vectors++;
    if (READDATA !== 128'h0) begin
      miscompares++; $display("FAIL reset_readdata: got %h expected 0", READDATA);
    end
    vectors++;
    if (BUSYWAIT !== 1'b0) begin
      miscompares++; $display("FAIL reset_busywait: got %b expected 0", BUSYWAIT);
    end
    do_req(1'b1, 1'b0, 28'd7, '0, busy);
    vectors++;
    if (READDATA !== ref_rdata) begin
      miscompares++; $display("FAIL reset_read7: got %h expected %h", READDATA, ref_rdata);
    end
    vectors++;
    if (busy !== LAT + 1) begin
      miscompares++; $display("FAIL reset_read7_busy: got %0d expected %0d", busy, LAT + 1);
    end
  endtask

  task automatic test_write_read();
    int busy;
    logic [127:0] prev;
    prev = ref_rdata;
    do_req(1'b0, 1'b1, 28'd3, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, busy);
    vectors++;
    if (busy !== LAT + 1) begin
      miscompares++; $display("FAIL wr3_busy: got %0d expected %0d", busy, LAT + 1);
    end
    vectors++;
    if (READDATA !== prev) begin
      miscompares++; $display("FAIL wr3_rdata_hold: got %h expected %h", READDATA, prev);
    end
    do_req(1'b1, 1'b0, 28'd3, '0, busy);
    vectors++;
    if (busy !== LAT + 1) begin
      miscompares++; $display("FAIL rd3_busy: got %0d expected %0d", busy, LAT + 1);
    end
    vectors++;
    if (READDATA !== 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210) begin
      miscompares++; $display("FAIL rd3_data: got %h expected 0123456789abcdeffedcba9876543210", READDATA);
    end
    @(posedge CLK); #2;
    vectors++;
    if (BUSYWAIT !== 1'b0) begin
      miscompares++; $display("FAIL idle_after_done: got %b expected 0", BUSYWAIT);
    end
  endtask

  task automatic test_alias();
    int busy;
    do_req(1'b0, 1'b1, 28'd67, {16{8'hA5}}, busy);
    do_req(1'b1, 1'b0, 28'd3, '0, busy);
    vectors++;
    if (READDATA !== {16{8'hA5}}) begin
      miscompares++; $display("FAIL alias_rd3: got %h expected %h", READDATA, {16{8'hA5}});
    end
  endtask

  task automatic test_read_write_both();
    int busy;
    logic [127:0] prev;
    prev = ref_rdata;
    do_req(1'b1, 1'b1, 28'd5, 128'h1, busy);
    vectors++;
    if (READDATA !== prev) begin
      miscompares++; $display("FAIL both_rdata_hold: got %h expected %h", READDATA, prev);
    end
    do_req(1'b1, 1'b0, 28'd5, '0, busy);
    vectors++;
    if (READDATA !== 128'h1) begin
      miscompares++; $display("FAIL both_mem5: got %h expected 1", READDATA);
    end
  endtask

  task automatic test_reset_mid_access();
    int busy;
    @(posedge CLK); #1;
    WRITE = 1'b1; ADDRESS = 28'd9; WRITEDATA = 128'hFF;
    @(posedge CLK);
    @(posedge CLK); #1;
    vectors++;
    if (BUSYWAIT !== 1'b1) begin
      miscompares++; $display("FAIL midrst_busy_before: got %b expected 1", BUSYWAIT);
    end
    RESET = 1'b1; WRITE = 1'b0;
    #1;
    vectors++;
    if (BUSYWAIT !== 1'b0) begin
      miscompares++; $display("FAIL midrst_busy_drop: got %b expected 0", BUSYWAIT);
    end
    vectors++;
    if (READDATA !== 128'h0) begin
      miscompares++; $display("FAIL midrst_rdata_clear: got %h expected 0", READDATA);
    end
    RESET = 1'b0;
    ref_reset();
    do_req(1'b1, 1'b0, 28'd9, '0, busy);
    vectors++;
    if (READDATA !== ref_rdata) begin
      miscompares++; $display("FAIL midrst_rd9: got %h expected %h", READDATA, ref_rdata);
    end
    do_req(1'b1, 1'b0, 28'd5, '0, busy);
    vectors++;
    if (READDATA !== ref_rdata) begin
      miscompares++; $display("FAIL midrst_rd5_cleared: got %h expected %h", READDATA, ref_rdata);
    end
  endtask

  task automatic test_drop_mid_busy();
    int busy;
    logic [27:0] a;
    logic [127:0] d;
    a = {22'($urandom), 6'($urandom_range(10, 20))};
    d = rand_block();
    do_req(1'b0, 1'b1, a, d, busy);
    @(posedge CLK); #1;
    READ = 1'b1; ADDRESS = a;
    @(posedge CLK);
    @(posedge CLK); #1;
    READ = 1'b0;
    busy = 0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (!BUSYWAIT) break;
      busy++;
      @(posedge CLK); #1;
    end
    ref_access(1'b1, 1'b0, a, '0);
    vectors++;
    if (busy !== LAT - 1) begin
      miscompares++; $display("FAIL drop_busy_tail: got %0d expected %0d", busy, LAT - 1);
    end
    vectors++;
    if (READDATA !== ref_rdata) begin
      miscompares++; $display("FAIL drop_rdata: got %h expected %h", READDATA, ref_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int busy;
    logic [27:0] a;
    logic [127:0] d1, d2;
    logic [13:0] pat, exp_pat;
    a = 28'($urandom);
    d1 = rand_block();
    d2 = rand_block();
    for (int i = 0; i < 14; i++) exp_pat[i] = ((i % (LAT + 2)) != (LAT + 1));
    @(posedge CLK); #1;
    WRITE = 1'b1; ADDRESS = a; WRITEDATA = d1;
    for (int i = 0; i < 14; i++) begin
      #1;
      pat[i] = BUSYWAIT;
      if (i == LAT + 1) WRITEDATA = d2;
      if (i != 13) begin
        @(posedge CLK); #1;
      end
    end
    WRITE = 1'b0;
    ref_access(1'b0, 1'b1, a, d1);
    ref_access(1'b0, 1'b1, a, d2);
    vectors++;
    if (pat !== exp_pat) begin
      miscompares++; $display("FAIL b2b_busy_pattern: got %b expected %b", pat, exp_pat);
    end
    do_req(1'b1, 1'b0, a, '0, busy);
    vectors++;
    if (READDATA !== ref_rdata) begin
      miscompares++; $display("FAIL b2b_rd: got %h expected %h", READDATA, ref_rdata);
    end
  endtask

  task automatic test_random();
    int busy;
    int op;
    logic [27:0] a;
    logic [127:0] d;
    for (int n = 0; n < 24; n++) begin
      op = int'($urandom_range(0, 2));
      a = {22'($urandom), 6'($urandom_range(0, 7))};
      d = rand_block();
      do_req(op != 1, op != 0, a, d, busy);
      vectors++;
      if (busy !== LAT + 1) begin
        miscompares++; $display("FAIL rand%0d_busy: got %0d expected %0d", n, busy, LAT + 1);
      end
      vectors++;
      if (READDATA !== ref_rdata) begin
        miscompares++; $display("FAIL rand%0d_rdata op=%0d: got %h expected %h", n, op, READDATA, ref_rdata);
      end
    end
  endtask

  initial begin
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
    ref_reset();
    #1 RESET = 1'b0;
    test_reset();
    test_write_read();
    test_alias();
    test_read_write_both();
    test_reset_mid_access();
    test_drop_mid_busy();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1);
  end

endmodule : tb_pipeline_data_memory
